// File: rtl/uart_wb_bridge.sv
// -----------------------------------------------------------------------------
// uart_wb_bridge
//
// Serial-to-Wishbone debug bridge. A host sends 8N1 command frames on rx_i and
// the bridge issues single 32-bit Wishbone classic master cycles:
//   Write : 'W' (0x57), A3..A0, D3..D0   -> reply 'K' (0x4B) after ack
//   Read  : 'R' (0x52), A3..A0           -> reply D3..D0 (read word, MSB first)
// Any other byte seen while idle is dropped. Baud rate is fixed by CLK_DIV.
//
// Parameters
//   CLK_DIV       clock cycles per serial bit (4..65535)
//   TIMEOUT_BITS  inter-byte gap, in bit times, that aborts a partial command
//
// Ports
//   wb_clk_i   in   single clock for all logic
//   wb_rst_i   in   asynchronous active-high reset
//   wb_adr_o   out  [31:0] byte address of the cycle
//   wb_dat_o   out  [31:0] write data
//   wb_dat_i   in   [31:0] read data, captured on ack
//   wb_we_o    out  1 = write cycle
//   wb_sel_o   out  [3:0] 4'hF during a cycle, 4'h0 otherwise
//   wb_stb_o   out  strobe, high together with wb_cyc_o for the whole cycle
//   wb_cyc_o   out  cycle
//   wb_ack_i   in   slave acknowledge
//   rx_i       in   serial input (asynchronous, idle high)
//   tx_o       out  serial output (idle high)
//   busy_o     out  high whenever the command FSM is not idle
// -----------------------------------------------------------------------------
module uart_wb_bridge #(
  parameter int CLK_DIV      = 868,
  parameter int TIMEOUT_BITS = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i,
  input  logic        rx_i,
  output logic        tx_o,
  output logic        busy_o
);

  localparam logic [15:0] DIV_M1  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(CLK_DIV / 2 - 1);
  localparam logic [31:0] TO_LIM  = 32'(TIMEOUT_BITS * CLK_DIV);
  localparam logic [7:0]  OP_W    = 8'h57;
  localparam logic [7:0]  OP_R    = 8'h52;
  localparam logic [7:0]  RESP_K  = 8'h4B;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_RESP
  } state_t;

  // RX engine state
  logic        r_rx_meta;
  logic        r_rx_sync;
  logic        r_rx_last;
  logic        r_rx_busy;
  logic [15:0] r_rx_cnt;
  logic [3:0]  r_rx_bitn;
  logic [7:0]  r_rx_sh;
  logic [7:0]  r_rx_data;
  logic        r_rx_vld;
  logic        r_rx_ferr;

  // Command FSM and bus master state
  state_t      r_state;
  logic [1:0]  r_bcnt;
  logic        r_we;
  logic [31:0] r_adr;
  logic [31:0] r_dat;
  logic        r_cyc;
  logic [31:0] r_to_cnt;

  // Response / TX engine state
  logic [31:0] r_resp;
  logic [2:0]  r_left;
  logic        r_tx;
  logic        r_tx_act;
  logic [15:0] r_tx_cnt;
  logic [3:0]  r_tx_bitn;
  logic [8:0]  r_tx_sh;

  logic        w_tx_done;
  logic        w_tx_load;

  // ---------------------------------------------------------------------------
  // RX: 2-FF synchronizer, falling-edge start detect, mid-bit sampling.
  // bitn 0 = start-bit re-check, 1..8 = data LSB first, 9 = stop bit.
  // The engine returns to idle at the stop-bit sample so that the next start
  // edge, which may follow immediately, is never missed.
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_last <= 1'b1;
      r_rx_busy <= 1'b0;
      r_rx_cnt  <= '0;
      r_rx_bitn <= '0;
      r_rx_sh   <= '0;
      r_rx_data <= '0;
      r_rx_vld  <= 1'b0;
      r_rx_ferr <= 1'b0;
    end else begin
      r_rx_meta <= rx_i;
      r_rx_sync <= r_rx_meta;
      r_rx_last <= r_rx_sync;
      r_rx_vld  <= 1'b0;
      r_rx_ferr <= 1'b0;
      if (!r_rx_busy) begin
        if (r_rx_last && !r_rx_sync) begin
          r_rx_busy <= 1'b1;
          r_rx_cnt  <= HALF_M1;
          r_rx_bitn <= 4'd0;
        end
      end else if (r_rx_cnt != 16'd0) begin
        r_rx_cnt <= r_rx_cnt - 16'd1;
      end else begin
        r_rx_cnt <= DIV_M1;
        if (r_rx_bitn == 4'd0) begin
          // Line back high at half a bit: treat the edge as a glitch.
          if (r_rx_sync) r_rx_busy <= 1'b0;
          else           r_rx_bitn <= 4'd1;
        end else if (r_rx_bitn != 4'd9) begin
          r_rx_sh   <= {r_rx_sync, r_rx_sh[7:1]};
          r_rx_bitn <= r_rx_bitn + 4'd1;
        end else begin
          r_rx_busy <= 1'b0;
          if (r_rx_sync) begin
            r_rx_vld  <= 1'b1;
            r_rx_data <= r_rx_sh;
          end else begin
            r_rx_ferr <= 1'b1;
          end
        end
      end
    end
  end

  // The stop bit of a frame has run its full length.
  assign w_tx_done = r_tx_act && (r_tx_cnt == 16'd0) && (r_tx_bitn == 4'd9);
  // Start a new frame either from idle or directly after the previous stop
  // bit, which keeps multi-byte replies back to back.
  assign w_tx_load = (r_state == S_RESP) && (r_left != 3'd0) &&
                     (!r_tx_act || w_tx_done);

  // ---------------------------------------------------------------------------
  // Command FSM, Wishbone master and TX serializer.
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state   <= S_IDLE;
      r_bcnt    <= '0;
      r_we      <= 1'b0;
      r_adr     <= '0;
      r_dat     <= '0;
      r_cyc     <= 1'b0;
      r_to_cnt  <= '0;
      r_resp    <= '0;
      r_left    <= '0;
      r_tx      <= 1'b1;
      r_tx_act  <= 1'b0;
      r_tx_cnt  <= '0;
      r_tx_bitn <= '0;
      r_tx_sh   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_to_cnt <= '0;
          r_bcnt   <= '0;
          if (r_rx_vld && (r_rx_data == OP_W || r_rx_data == OP_R)) begin
            r_state <= S_ADDR;
            r_we    <= (r_rx_data == OP_W);
          end
        end

        S_ADDR, S_DATA: begin
          if (r_rx_ferr) begin
            r_state <= S_IDLE;
          end else if (r_rx_vld) begin
            r_to_cnt <= '0;
            r_bcnt   <= r_bcnt + 2'd1;
            if (r_state == S_ADDR) r_adr <= {r_adr[23:0], r_rx_data};
            else                   r_dat <= {r_dat[23:0], r_rx_data};
            if (r_bcnt == 2'd3) begin
              if (r_state == S_ADDR && r_we) begin
                r_state <= S_DATA;
              end else begin
                r_state <= S_BUS;
                r_cyc   <= 1'b1;
              end
            end
          end else if (r_to_cnt == TO_LIM) begin
            r_state <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 32'd1;
          end
        end

        S_BUS: begin
          if (wb_ack_i) begin
            r_cyc   <= 1'b0;
            r_state <= S_RESP;
            if (r_we) begin
              r_resp <= {RESP_K, 24'h0};
              r_left <= 3'd1;
            end else begin
              r_resp <= wb_dat_i;
              r_left <= 3'd4;
            end
          end
        end

        S_RESP: begin
          if (w_tx_done && r_left == 3'd0) r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase

      // TX serializer: start bit, 8 data bits LSB first, stop bit.
      if (w_tx_load) begin
        r_tx      <= 1'b0;
        r_tx_sh   <= {1'b1, r_resp[31:24]};
        r_resp    <= {r_resp[23:0], 8'h00};
        r_left    <= r_left - 3'd1;
        r_tx_cnt  <= DIV_M1;
        r_tx_bitn <= 4'd0;
        r_tx_act  <= 1'b1;
      end else if (r_tx_act) begin
        if (r_tx_cnt != 16'd0) begin
          r_tx_cnt <= r_tx_cnt - 16'd1;
        end else if (w_tx_done) begin
          r_tx_act <= 1'b0;
        end else begin
          r_tx      <= r_tx_sh[0];
          r_tx_sh   <= {1'b1, r_tx_sh[8:1]};
          r_tx_bitn <= r_tx_bitn + 4'd1;
          r_tx_cnt  <= DIV_M1;
        end
      end
    end
  end

  assign wb_adr_o = r_adr;
  assign wb_dat_o = r_dat;
  assign wb_we_o  = r_we;
  assign wb_cyc_o = r_cyc;
  assign wb_stb_o = r_cyc;
  assign wb_sel_o = r_cyc ? 4'hF : 4'h0;
  assign tx_o     = r_tx;
  assign busy_o   = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_wb_bridge.sv
// -----------------------------------------------------------------------------
// tb_uart_wb_bridge
//
// Scoreboard bench for uart_wb_bridge at CLK_DIV=8. Stimulus pushes expected
// bus cycles and expected reply bytes into queues; a bus monitor and a serial
// TX decoder pop and compare whenever the DUT presents a cycle or a frame.
// -----------------------------------------------------------------------------
module tb_uart_wb_bridge;

  localparam int DIV = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr_o, dat_o, dat_i;
  logic        we_o, stb_o, cyc_o, ack_i;
  logic [3:0]  sel_o;
  logic        rx = 1'b1;
  logic        tx_o, busy_o;

  uart_wb_bridge #(.CLK_DIV(DIV), .TIMEOUT_BITS(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wb_adr_o(adr_o), .wb_dat_o(dat_o), .wb_dat_i(dat_i),
    .wb_we_o(we_o), .wb_sel_o(sel_o), .wb_stb_o(stb_o), .wb_cyc_o(cyc_o),
    .wb_ack_i(ack_i), .rx_i(rx), .tx_o(tx_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    int          len;
  } bus_t;

  bus_t       bus_q[$];
  logic [7:0] tx_q[$];
  int         tx_starts[$];

  int          slv_ws    = 0;
  logic        slv_hold  = 1'b0;
  logic [31:0] slv_rdata = 32'h0;
  logic        rst_abort = 1'b0;

  // Wishbone slave: ack after slv_ws wait states, read data only during ack.
  initial begin
    int cnt;
    cnt   = 0;
    ack_i = 1'b0;
    dat_i = 32'h0BAD0BAD;
    forever begin
      @(negedge clk);
      if (cyc_o && stb_o && !slv_hold && cnt == slv_ws) begin
        ack_i = 1'b1;
        dat_i = slv_rdata;
      end else begin
        ack_i = 1'b0;
        dat_i = 32'h0BAD0BAD;
      end
      if (cyc_o && stb_o) cnt++;
      else                cnt = 0;
    end
  end

  // Bus monitor: checks each cycle against the next expected record.
  initial begin
    logic prev;
    logic have;
    int   len;
    bus_t e;
    prev = 1'b0;
    have = 1'b0;
    len  = 0;
    forever begin
      @(negedge clk);
      if (stb_o && !prev) begin
        len = 1;
        if (bus_q.size() == 0) begin
          have = 1'b0;
          checks++;
          errors++;
          $display("FAIL bus_unexpected adr=%h we=%b expected no cycle", adr_o, we_o);
        end else begin
          e    = bus_q.pop_front();
          have = 1'b1;
          check("bus_adr", adr_o, e.adr);
          check("bus_we", 32'(we_o), 32'(e.we));
          if (e.we) check("bus_dat", dat_o, e.dat);
          check("bus_sel", 32'(sel_o), 32'h0000000F);
          check("bus_cyc", 32'(cyc_o), 32'd1);
        end
      end else if (stb_o) begin
        len++;
      end else if (prev && have) begin
        if (!rst_abort) check("bus_stb_len", 32'(len), 32'(e.len));
        have = 1'b0;
      end
      prev = stb_o;
    end
  end

  // Serial TX decoder: samples each bit at its centre.
  initial begin
    logic [7:0] b;
    logic [7:0] exp_b;
    b = 8'h00;
    forever begin
      @(negedge clk);
      if (tx_o === 1'b0 && !rst) begin
        tx_starts.push_back(cyc_n);
        repeat (DIV/2) @(negedge clk);
        check("tx_start_bit", 32'(tx_o), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = tx_o;
        end
        repeat (DIV) @(negedge clk);
        check("tx_stop_bit", 32'(tx_o), 32'd1);
        if (tx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected byte=%h expected none", b);
        end else begin
          exp_b = tx_q.pop_front();
          check("tx_byte", 32'(b), 32'(exp_b));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc_n);
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = stop;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_w(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] t;
    send_byte(8'h57, 1'b1);
    t = a;
    for (int i = 0; i < 4; i++) begin send_byte(t[31:24], 1'b1); t = t << 8; end
    t = d;
    for (int i = 0; i < 4; i++) begin send_byte(t[31:24], 1'b1); t = t << 8; end
  endtask

  task automatic send_r(input logic [31:0] a);
    logic [31:0] t;
    send_byte(8'h52, 1'b1);
    t = a;
    for (int i = 0; i < 4; i++) begin send_byte(t[31:24], 1'b1); t = t << 8; end
  endtask

  task automatic expect_w(input logic [31:0] a, input logic [31:0] d, input int ws);
    bus_t e;
    e.adr = a; e.dat = d; e.we = 1'b1; e.len = ws + 1;
    slv_ws = ws;
    bus_q.push_back(e);
    tx_q.push_back(8'h4B);
  endtask

  task automatic expect_r(input logic [31:0] a, input logic [31:0] d, input int ws);
    bus_t e;
    e.adr = a; e.dat = 32'h0; e.we = 1'b0; e.len = ws + 1;
    slv_ws    = ws;
    slv_rdata = d;
    bus_q.push_back(e);
    tx_q.push_back(d[31:24]);
    tx_q.push_back(d[23:16]);
    tx_q.push_back(d[15:8]);
    tx_q.push_back(d[7:0]);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((busy_o || tx_q.size() != 0 || bus_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout busy=%b tx_left=%0d bus_left=%0d required all zero",
               name, busy_o, tx_q.size(), bus_q.size());
    end else begin
      check({name, "_busy"}, 32'(busy_o), 32'd0);
    end
    repeat (2*DIV) @(negedge clk);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx_o), 32'd1);
    check("rst_cyc", 32'(cyc_o), 32'd0);
    check("rst_stb", 32'(stb_o), 32'd0);
    check("rst_we", 32'(we_o), 32'd0);
    check("rst_sel", 32'(sel_o), 32'd0);
    check("rst_adr", adr_o, 32'd0);
    check("rst_dat", dat_o, 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Write with a zero-wait-state slave.
    expect_w(32'h10000004, 32'hDEADBEEF, 0);
    send_w(32'h10000004, 32'hDEADBEEF);
    wait_done("t1_write");

    // Read with 3 wait states, reply bytes must be back to back.
    tx_starts.delete();
    expect_r(32'h10000000, 32'h12345678, 3);
    send_r(32'h10000000);
    wait_done("t2_read");
    check("t2_nframes", 32'(tx_starts.size()), 32'd4);
    if (tx_starts.size() == 4)
      for (int i = 1; i < 4; i++)
        check("t2_frame_spacing", 32'(tx_starts[i] - tx_starts[i-1]), 32'(10*DIV));

    // Junk bytes in idle are dropped.
    expect_r(32'hA5A50010, 32'h0F1E2D3C, 1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    repeat (DIV) @(negedge clk);
    check("t3_junk_busy", 32'(busy_o), 32'd0);
    send_r(32'hA5A50010);
    wait_done("t3_read");

    // Partial write aborted by inter-byte timeout, then a clean read.
    expect_r(32'h20000008, 32'hCAFEF00D, 0);
    send_byte(8'h57, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h00, 1'b1);
    check("t4_partial_busy", 32'(busy_o), 32'd1);
    repeat (17*DIV) @(negedge clk);
    check("t4_timeout_busy", 32'(busy_o), 32'd0);
    send_r(32'h20000008);
    wait_done("t4_read");

    // Framing error on an address byte returns to idle with no bus cycle.
    send_byte(8'h52, 1'b1);
    send_byte(8'h33, 1'b0);
    repeat (DIV) @(negedge clk);
    check("t5_ferr_busy", 32'(busy_o), 32'd0);
    repeat (20*DIV) @(negedge clk);
    check("t5_no_cycle_pending", 32'(bus_q.size()), 32'd0);

    // Reset while the bus cycle waits for ack.
    begin
      bus_t e;
      e.adr = 32'h3000000C; e.dat = 32'h0; e.we = 1'b0; e.len = 0;
      bus_q.push_back(e);
    end
    slv_hold = 1'b1;
    send_r(32'h3000000C);
    n = 0;
    while (!stb_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t6_stb_seen", 32'(stb_o), 32'd1);
    repeat (2) @(negedge clk);
    rst_abort = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("t6_rst_cyc", 32'(cyc_o), 32'd0);
    check("t6_rst_stb", 32'(stb_o), 32'd0);
    check("t6_rst_tx", 32'(tx_o), 32'd1);
    check("t6_rst_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    slv_hold = 1'b0;
    repeat (5) @(negedge clk);
    rst_abort = 1'b0;
    expect_w(32'h40000000, 32'h11223344, 2);
    send_w(32'h40000000, 32'h11223344);
    wait_done("t6_write");

    check("final_bus_q", 32'(bus_q.size()), 32'd0);
    check("final_tx_q", 32'(tx_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
